// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs X/M loads/stores against a variable-latency memory,
// stalling upstream while busy. Optional timeout abort guarded by MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        halt_in,
  input  logic [15:0] ALUresult_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  Source2_in,
  input  logic        RegWrite_w,
  input  logic [3:0]  reg_dest_w,
  input  logic [15:0] wb_data_w,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        mem_stall,
  output logic        RegWrite_out,
  output logic [15:0] read_data_out,
  output logic        mem_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [15:0] wdata_q, wdata_d;
  logic        access;
  logic        fwd;
  logic [15:0] fwd_data;
  logic        timeout;

  assign access   = (MemRead_in | MemWrite_in) & ~halt_in;
  assign fwd      = RegWrite_w & (reg_dest_w == Source2_in) & (reg_dest_w != 4'd0);
  assign fwd_data = fwd ? wb_data_w : b_in;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q;

  // Fires in the last allowed BUSY cycle so the stall can be released in that cycle.
  assign timeout = (state_q == StBusy) & ~mem_data_valid &
                   ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      if (access) cnt_d = '0;
    end else if (!mem_data_valid && (cnt_q != CntW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | timeout;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d = StBusy;
          wdata_d = fwd_data;
        end
      end
      StBusy: begin
        if (mem_data_valid || timeout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = ALUresult_in;
    mem_wdata     = fwd_data;
    mem_stall     = 1'b0;
    read_data_out = 16'h0000;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          mem_en    = 1'b1;
          mem_wr    = MemWrite_in;
          mem_stall = 1'b1;
        end
      end
      StBusy: begin
        // W stage has moved on; store data comes from the captured copy.
        mem_en    = 1'b1;
        mem_wr    = MemWrite_in;
        mem_wdata = wdata_q;
        mem_stall = ~mem_data_valid & ~timeout;
        if (mem_data_valid) read_data_out = mem_rdata;
      end
      default: ;
    endcase
  end

  assign RegWrite_out = RegWrite_in & ~mem_stall & ~timeout;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected transactions queued at request,
// popped and compared at memory completion.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemRead_in, MemWrite_in, halt_in;
  logic [15:0] ALUresult_in, b_in;
  logic [3:0]  Source2_in;
  logic        RegWrite_w;
  logic [3:0]  reg_dest_w;
  logic [15:0] wb_data_w;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_valid;
  logic        mem_stall, RegWrite_out;
  logic [15:0] read_data_out;
  logic        mem_err;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .RegWrite_in    (RegWrite_in),
    .MemRead_in     (MemRead_in),
    .MemWrite_in    (MemWrite_in),
    .halt_in        (halt_in),
    .ALUresult_in   (ALUresult_in),
    .b_in           (b_in),
    .Source2_in     (Source2_in),
    .RegWrite_w     (RegWrite_w),
    .reg_dest_w     (reg_dest_w),
    .wb_data_w      (wb_data_w),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_data_valid (mem_data_valid),
    .mem_stall      (mem_stall),
    .RegWrite_out   (RegWrite_out),
    .read_data_out  (read_data_out),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    RegWrite_in    = 1'b0;
    MemRead_in     = 1'b0;
    MemWrite_in    = 1'b0;
    halt_in        = 1'b0;
    ALUresult_in   = 16'h0;
    b_in           = 16'h0;
    Source2_in     = 4'h0;
    RegWrite_w     = 1'b0;
    reg_dest_w     = 4'h0;
    wb_data_w      = 16'h0;
    mem_rdata      = 16'h0;
    mem_data_valid = 1'b0;
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] b, input logic [3:0] src2, input logic rw_w,
                           input logic [3:0] dest_w, input logic [15:0] wb_w,
                           input logic rw_in, input int lat, input logic [15:0] rdata);
    exp_t e, got_e;
    int   stalls;
    @(posedge clk); #1;
    RegWrite_in  = rw_in;
    MemRead_in   = rd;
    MemWrite_in  = wr;
    ALUresult_in = addr;
    b_in         = b;
    Source2_in   = src2;
    RegWrite_w   = rw_w;
    reg_dest_w   = dest_w;
    wb_data_w    = wb_w;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = (rw_w && (dest_w == src2) && (dest_w != 4'd0)) ? wb_w : b;
    e.rdata = rdata;
    e.rw    = rw_in;
    exp_q.push_back(e);
    stalls = 0;
    @(negedge clk);
    check_eq("req_en", mem_en, 1'b1);
    check_eq("req_wr", mem_wr, e.wr);
    check_eq("req_addr", mem_addr, e.addr);
    check_eq("req_wdata", mem_wdata, e.wdata);
    check_eq("req_regwrite", RegWrite_out, 1'b0);
    if (mem_stall) stalls++;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      RegWrite_w     = ~rw_w;
      reg_dest_w     = dest_w + 4'd1;
      wb_data_w      = ~wb_w;
      mem_data_valid = (k == lat);
      mem_rdata      = (k == lat) ? rdata : 16'($urandom);
      @(negedge clk);
      check_eq("busy_en", mem_en, 1'b1);
      check_eq("busy_wr", mem_wr, e.wr);
      check_eq("busy_addr", mem_addr, e.addr);
      check_eq("busy_wdata", mem_wdata, e.wdata);
      if (mem_stall) stalls++;
      if (k == lat) begin
        got_e = exp_q.pop_front();
        check_eq("done_rdata", read_data_out, got_e.rdata);
        check_eq("done_regwrite", RegWrite_out, got_e.rw);
      end else begin
        check_eq("busy_rdata_zero", read_data_out, 16'h0);
        check_eq("busy_regwrite", RegWrite_out, 1'b0);
      end
    end
    check_eq("stall_cycles", stalls, lat);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_eq("after_en", mem_en, 1'b0);
    check_eq("after_stall", mem_stall, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #12;
    check_eq("rst_en", mem_en, 1'b0);
    check_eq("rst_stall", mem_stall, 1'b0);
    check_eq("rst_err", mem_err, 1'b0);
    check_eq("rst_rdata", read_data_out, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load, store with forward, store without forward from r0, rd+wr, minimum latency
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 3, 16'hBEEF);
    do_access(1'b0, 1'b1, 16'h0080, 16'h1111, 4'd5, 1'b1, 4'd5, 16'h2222, 1'b0, 4, 16'h0000);
    do_access(1'b0, 1'b1, 16'h0080, 16'h1111, 4'd0, 1'b1, 4'd0, 16'h2222, 1'b0, 4, 16'h0000);
    do_access(1'b1, 1'b1, 16'h00C4, 16'h3333, 4'd7, 1'b1, 4'd6, 16'h4444, 1'b0, 2, 16'h0000);
    do_access(1'b1, 1'b0, 16'hFFFE, 16'h0000, 4'd2, 1'b0, 4'd2, 16'h9999, 1'b1, 1, 16'hA5C3);

    // Halt suppresses the access; spurious valid in IDLE is ignored
    @(posedge clk); #1;
    halt_in = 1'b1; MemRead_in = 1'b1; RegWrite_in = 1'b1; ALUresult_in = 16'h0010;
    @(negedge clk);
    check_eq("halt_en", mem_en, 1'b0);
    check_eq("halt_stall", mem_stall, 1'b0);
    check_eq("halt_regwrite", RegWrite_out, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    mem_data_valid = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    check_eq("spur_en", mem_en, 1'b0);
    check_eq("spur_rdata", read_data_out, 16'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_eq("spur_after_en", mem_en, 1'b0);
    check_eq("spur_after_stall", mem_stall, 1'b0);
    do_access(1'b1, 1'b0, 16'h0200, 16'h0000, 4'd1, 1'b0, 4'd0, 16'h0000, 1'b1, 2, 16'h5151);

    // Reset in BUSY cycle 2
    @(posedge clk); #1;
    MemWrite_in = 1'b1; ALUresult_in = 16'h0100; b_in = 16'h5A5A; Source2_in = 4'd3;
    @(negedge clk);
    check_eq("rstmid_req_stall", mem_stall, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rstmid_busy_stall", mem_stall, 1'b1);
      check_eq("rstmid_busy_wdata", mem_wdata, 16'h5A5A);
    end
    rst = 1'b1;
    idle_inputs();
    #1;
    check_eq("rstmid_stall", mem_stall, 1'b0);
    check_eq("rstmid_en", mem_en, 1'b0);
    check_eq("rstmid_wdata_q", dut.wdata_q, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_access(1'b0, 1'b1, 16'h0300, 16'h6789, 4'd4, 1'b0, 4'd4, 16'h0000, 1'b0, 2, 16'h0000);

    // Valid never arrives
    @(posedge clk); #1;
    MemRead_in = 1'b1; RegWrite_in = 1'b1; ALUresult_in = 16'h0400;
    @(negedge clk);
    check_eq("to_req_stall", mem_stall, 1'b1);
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      check_eq("to_stall", mem_stall, (k < 4));
      check_eq("to_regwrite", RegWrite_out, 1'b0);
      check_eq("to_rdata", read_data_out, 16'h0);
      check_eq("to_err_pre", mem_err, 1'b0);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_eq("to_idle_en", mem_en, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("to_err_sticky", mem_err, 1'b1);
    end
    rst = 1'b1;
    #1;
    check_eq("to_err_cleared", mem_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
`else
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("noto_stall", mem_stall, 1'b1);
      check_eq("noto_err", mem_err, 1'b0);
    end
    @(posedge clk); #1;
    mem_data_valid = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    check_eq("noto_done_stall", mem_stall, 1'b0);
    check_eq("noto_done_rdata", read_data_out, 16'h7777);
    @(posedge clk); #1;
    idle_inputs();
`endif
    @(negedge clk);
    check_eq("end_en", mem_en, 1'b0);
    check_eq("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
